run_done_controller: RTL and testbench
======================================

// Module: run_done_controller
// PURPOSE
//  Initiator side of the Versat unit run/running/done protocol. Issues one run pulse to NUM_UNITS units
//  and holds running until every unit reports done or a timeout expires.
//  Reports completion (pulse), running-cycle count and timeout status to the control/CPU interface.
//  Sits between the accelerator control registers and the unit array.
// PARAMETERS
//  NUM_UNITS  4   number of unit done inputs (>=1)
//  CYCLE_W    16  width of running-cycle counter, timeout config and cycles output
// PORTS
//  clk        in   1          clock
//  rst        in   1          asynchronous, active-low reset
//  start      in   1          run request; sampled only in IDLE
//  timeout    in   CYCLE_W    max running cycles; 0 = no timeout; latched on accepted start
//  done_in    in   NUM_UNITS  per-unit done, valid only while running
//  run        out  1          1-cycle run pulse to all units
//  running    out  1          high for whole execution phase
//  busy       out  1          high in every state except IDLE
//  finished   out  1          1-cycle completion pulse
//  timed_out  out  1          last run ended by timeout; held until next accepted start
//  cycles     out  CYCLE_W    running cycles of last run; held until next finish
// BEHAVIOUR
//  Reset (rst low, async): state IDLE. All outputs 0: run, running, busy, finished, timed_out, cycles.
//    Counter also 0. Applies immediately, including mid-run; no finished pulse is emitted.
//  FSM IDLE->RUN->SETTLE->WAIT->FINISH->IDLE:
//   IDLE:   outputs low except held timed_out/cycles.
//           start=1 at edge -> RUN; timeout latched, counter cleared, timed_out cleared.
//   RUN:    run=1, running=0, busy=1; always -> SETTLE next cycle.
//   SETTLE: running=1; done_in ignored (stale values); counter+1.
//           Timeout check applies -> WAIT or FINISH.
//   WAIT:   running=1; counter+1 each cycle.
//           allDone = &done_in -> FINISH.
//           Else latched timeout!=0 and counter==timeout -> FINISH with timed_out=1.
//           Else stay.
//   FINISH: running=0, finished=1, cycles<=counter; -> IDLE.
//  Counter = number of running-high cycles including the cycle done is seen.
//    Saturates at all-ones, no wrap.
//  Minimum latency with all done high: start edge T -> run in T+1, running in T+2..T+3.
//    finished in T+4, cycles=2.
//  Simultaneous allDone and timeout match in the same cycle: completion wins, timed_out=0.
//  timeout=1: ends after SETTLE, cycles=1, timed_out=1.
//  start during RUN/SETTLE/WAIT/FINISH: ignored, not queued.
//    start high in FINISH's following IDLE cycle is accepted (back-to-back runs).
//  timeout changes after acceptance: no effect on current run.
// CONFIGURATION
//  RUN_CTRL_DONE_MASK_EN defined: adds input done_mask[NUM_UNITS], latched on accepted start.
//    allDone = &(done_in | mask_latched); masked units never block completion.
//    All-ones mask completes on first WAIT cycle.
//  Not defined: no done_mask port; allDone = &done_in.
// TESTING
//  1 All done_in=1, timeout=0, start pulse -> run 1 cycle; running 2 cycles; finished at start+4.
//    cycles=2, timed_out=0.
//  2 done_in bits rise after 3,7,10,5 running cycles -> running stays high 10 cycles.
//    finished next cycle, cycles=10.
//  3 timeout=8, unit 1 never done -> running 8 cycles, finished pulse, timed_out=1, cycles=8.
//    Next start clears timed_out.
//  4 start held high continuously -> exactly one run pulse per run.
//    New run begins the cycle after FINISH returns to IDLE; run pulses never overlap running.
//  5 rst low in WAIT cycle 4 -> run/running/busy/finished/cycles=0 immediately, no finished pulse.
//    After release, start gives normal test-1 timing.
//  6 (RUN_CTRL_DONE_MASK_EN) done_mask=4'b0100, unit 2 done stuck 0, others high.
//    Completes as test 1, timed_out=0.

Source files
------------

// File: rtl/run_done_if.sv
// Run/running/done handshake between the run controller and its CPU/unit-array side.
// Carries done_mask only when RUN_CTRL_DONE_MASK_EN is defined.
interface run_done_if #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned CYCLE_W   = 16
);
    logic                 start;
    logic [CYCLE_W-1:0]   timeout;
    logic [NUM_UNITS-1:0] done_in;
`ifdef RUN_CTRL_DONE_MASK_EN
    logic [NUM_UNITS-1:0] done_mask;
`endif
    logic                 run;
    logic                 running;
    logic                 busy;
    logic                 finished;
    logic                 timed_out;
    logic [CYCLE_W-1:0]   cycles;

`ifdef RUN_CTRL_DONE_MASK_EN
    modport master (
        input  start, timeout, done_in, done_mask,
        output run, running, busy, finished, timed_out, cycles
    );
    modport slave (
        output start, timeout, done_in, done_mask,
        input  run, running, busy, finished, timed_out, cycles
    );
`else
    modport master (
        input  start, timeout, done_in,
        output run, running, busy, finished, timed_out, cycles
    );
    modport slave (
        output start, timeout, done_in,
        input  run, running, busy, finished, timed_out, cycles
    );
`endif
endinterface

// File: rtl/run_done_controller.sv
// Initiator of the unit run/running/done protocol: one run pulse, running until all done or timeout.
// Optional feature macro: RUN_CTRL_DONE_MASK_EN (per-unit done mask latched on start).
module run_done_controller #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned CYCLE_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    run_done_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CYCLE_W-1:0]   cnt_q, cnt_d;
    logic [CYCLE_W-1:0]   tmo_q, tmo_d;
    logic [CYCLE_W-1:0]   cycles_q, cycles_d;
    logic                 timed_out_q, timed_out_d;
    logic                 run_q, run_d;
    logic                 running_q, running_d;
    logic                 busy_q, busy_d;
    logic                 finished_q, finished_d;
    logic [CYCLE_W-1:0]   cnt_inc_c;
    logic                 all_done_c;
    logic                 tmo_hit_c;

`ifdef RUN_CTRL_DONE_MASK_EN
    logic [NUM_UNITS-1:0] mask_q, mask_d;
    assign all_done_c = &(bus.done_in | mask_q);
`else
    assign all_done_c = &bus.done_in;
`endif

    // Saturating increment; the timeout compare sees the count including the current cycle
    assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CYCLE_W'(1);
    assign tmo_hit_c = (tmo_q != '0) && (cnt_inc_c == tmo_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        cycles_d    = cycles_q;
        timed_out_d = timed_out_q;
`ifdef RUN_CTRL_DONE_MASK_EN
        mask_d      = mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_RUN;
                    tmo_d       = bus.timeout;
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
`ifdef RUN_CTRL_DONE_MASK_EN
                    mask_d      = bus.done_mask;
`endif
                end
            end
            S_RUN: state_d = S_SETTLE;
            S_SETTLE: begin
                // done_in may still hold values from a previous run here
                cnt_d = cnt_inc_c;
                if (tmo_hit_c) begin
                    state_d     = S_FINISH;
                    timed_out_d = 1'b1;
                    cycles_d    = cnt_inc_c;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc_c;
                if (all_done_c) begin
                    state_d  = S_FINISH;
                    cycles_d = cnt_inc_c;
                end else if (tmo_hit_c) begin
                    state_d     = S_FINISH;
                    timed_out_d = 1'b1;
                    cycles_d    = cnt_inc_c;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        run_d      = (state_d == S_RUN);
        running_d  = (state_d == S_SETTLE) || (state_d == S_WAIT);
        busy_d     = (state_d != S_IDLE);
        finished_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            cycles_q    <= '0;
            timed_out_q <= 1'b0;
            run_q       <= 1'b0;
            running_q   <= 1'b0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
`ifdef RUN_CTRL_DONE_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            cycles_q    <= cycles_d;
            timed_out_q <= timed_out_d;
            run_q       <= run_d;
            running_q   <= running_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
`ifdef RUN_CTRL_DONE_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    assign bus.run       = run_q;
    assign bus.running   = running_q;
    assign bus.busy      = busy_q;
    assign bus.finished  = finished_q;
    assign bus.timed_out = timed_out_q;
    assign bus.cycles    = cycles_q;

endmodule

// File: tb/tb_run_done_controller.sv
// Bench for run_done_controller: directed runs plus random runs against a per-run timing model.
// Optional mask checks are built only when RUN_CTRL_DONE_MASK_EN is defined.
module tb_run_done_controller;
    localparam int unsigned NUM_UNITS = 4;
    localparam int unsigned CYCLE_W   = 16;
    localparam int          NEVER     = 1000;

    logic clk;
    logic rst;
    int   vectors = 0;
    int   errs    = 0;
    logic exp_to  = 1'b0;
    int   exp_cyc = 0;

    run_done_if #(.NUM_UNITS(NUM_UNITS), .CYCLE_W(CYCLE_W)) bus ();

    run_done_controller #(.NUM_UNITS(NUM_UNITS), .CYCLE_W(CYCLE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One run. Unit u reports done from its rise[u]-th running cycle on; the model derives
    // the run length from the protocol rules and then checks every cycle of the run.
    task automatic do_run(input int tmo, input int r0, input int r1, input int r2, input int r3,
                          input logic [3:0] mask, input bit hold, input int abort_at);
        int   rise [4];
        int   d;
        int   e;
        logic to;
        int   k;
        logic [3:0] dn;
        rise = '{r0, r1, r2, r3};
        d = 2;
        for (int u = 0; u < 4; u++)
            if (!mask[u] && rise[u] > d) d = rise[u];
        if (tmo != 0 && tmo < d) begin
            e = tmo; to = 1'b1;
        end else begin
            e = d;   to = 1'b0;
        end

        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_run", 32'(bus.run), 32'd0);
        check("idle_running", 32'(bus.running), 32'd0);
        check("idle_timed_out", 32'(bus.timed_out), 32'(exp_to));
        check("idle_cycles", 32'(bus.cycles), 32'(exp_cyc));
        bus.start   = 1'b1;
        bus.timeout = CYCLE_W'(tmo);
        bus.done_in = 4'($urandom);
`ifdef RUN_CTRL_DONE_MASK_EN
        bus.done_mask = mask;
`endif

        for (int j = 1; j <= e + 2; j++) begin
            @(negedge clk);
            check("run", 32'(bus.run), 32'(j == 1));
            check("running", 32'(bus.running), 32'(j >= 2 && j <= e + 1));
            check("busy", 32'(bus.busy), 32'd1);
            check("finished", 32'(bus.finished), 32'(j == e + 2));
            if (j == 1) check("timed_out_clr", 32'(bus.timed_out), 32'd0);
            if (j == abort_at) begin
                bus.start = 1'b0;
                #1 rst = 1'b0;
                #1;
                check("rst_run", 32'(bus.run), 32'd0);
                check("rst_running", 32'(bus.running), 32'd0);
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_finished", 32'(bus.finished), 32'd0);
                check("rst_cycles", 32'(bus.cycles), 32'd0);
                check("rst_timed_out", 32'(bus.timed_out), 32'd0);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_hold_finished", 32'(bus.finished), 32'd0);
                    check("rst_hold_busy", 32'(bus.busy), 32'd0);
                end
                rst = 1'b1;
                exp_to  = 1'b0;
                exp_cyc = 0;
                return;
            end
            if (j == e + 2) begin
                check("fin_timed_out", 32'(bus.timed_out), 32'(to));
                check("fin_cycles", 32'(bus.cycles), 32'(e));
                exp_to  = to;
                exp_cyc = e;
                bus.start = hold;
            end else begin
                bus.start   = hold ? 1'b1 : 1'($urandom);
                bus.timeout = CYCLE_W'($urandom);
            end
            k = j - 1;
            if (j <= e + 1 && k >= 2) begin
                for (int u = 0; u < 4; u++) dn[u] = (k >= rise[u]);
                bus.done_in = dn;
            end else begin
                bus.done_in = 4'($urandom);
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.timeout = '0;
        bus.done_in = '0;
`ifdef RUN_CTRL_DONE_MASK_EN
        bus.done_mask = '0;
`endif
        repeat (2) @(negedge clk);
        check("por_run", 32'(bus.run), 32'd0);
        check("por_running", 32'(bus.running), 32'd0);
        check("por_busy", 32'(bus.busy), 32'd0);
        check("por_finished", 32'(bus.finished), 32'd0);
        check("por_timed_out", 32'(bus.timed_out), 32'd0);
        check("por_cycles", 32'(bus.cycles), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // minimum latency, all units done
        do_run(0, 0, 0, 0, 0, 4'b0000, 1'b0, 0);
        // staggered done rises
        do_run(0, 3, 7, 10, 5, 4'b0000, 1'b0, 0);
        // timeout with unit 1 stuck, then a run that must clear timed_out
        do_run(8, 0, NEVER, 0, 0, 4'b0000, 1'b0, 0);
        do_run(0, 4, 4, 4, 4, 4'b0000, 1'b0, 0);
        // timeout of 1 ends right after the settle cycle
        do_run(1, NEVER, 0, 0, 0, 4'b0000, 1'b0, 0);
        // done and timeout in the same cycle: completion wins
        do_run(6, 6, 2, 3, 6, 4'b0000, 1'b0, 0);
        // start held high across back-to-back runs
        do_run(0, 0, 0, 0, 0, 4'b0000, 1'b1, 0);
        do_run(5, 0, 3, 0, 0, 4'b0000, 1'b1, 0);
        do_run(0, 2, 2, 2, 2, 4'b0000, 1'b0, 0);
        // reset in the fourth wait cycle, then a normal minimum run
        do_run(0, 100, 100, 100, 100, 4'b0000, 1'b0, 6);
        do_run(0, 0, 0, 0, 0, 4'b0000, 1'b0, 0);
`ifdef RUN_CTRL_DONE_MASK_EN
        // masked unit 2 stuck low
        do_run(0, 0, 0, NEVER, 0, 4'b0100, 1'b0, 0);
        do_run(0, NEVER, NEVER, NEVER, NEVER, 4'b1111, 1'b0, 0);
`endif

        for (int i = 0; i < 24; i++) begin
            int tmo;
            int r [4];
            logic [3:0] m;
            bit h;
            tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 14));
            for (int u = 0; u < 4; u++) begin
                r[u] = int'($urandom_range(0, 12));
                if (tmo != 0 && $urandom_range(0, 3) == 0) r[u] = NEVER;
            end
`ifdef RUN_CTRL_DONE_MASK_EN
            m = 4'($urandom);
`else
            m = 4'b0000;
`endif
            h = (i < 23) ? 1'($urandom) : 1'b0;
            do_run(tmo, r[0], r[1], r[2], r[3], m, h, 0);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
